qam_mapper_upsampler: RTL and testbench

Parametrised successor to the fixed 16-QAM data upsampler in the modulator chain.
- Accepts one symbol per AXI-stream beat and maps it to Gray-coded QPSK, 16-QAM or 64-QAM, selected at run time.
- Emits UPSAMPLING_FACTOR complex samples per symbol, spaced by a prescaler, with full AXI-stream backpressure.
- Feeds the pulse-shaping FIR / interpolator on a single packed complex stream.

---
 rtl/qam_mapper_upsampler.sv | 166 ++++++++++++++++
 tb/tb_qam_mapper_upsampler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_mapper_upsampler.sv
// Gray-coded QPSK/16-QAM/64-QAM symbol mapper with prescaled upsampling onto a packed I/Q AXI stream.
// Define QAM_HOLD_MODE_EN for zero-order hold instead of zero-stuffing between symbol samples.
module qam_mapper_upsampler #(
  parameter int DATA_WIDTH        = 16,
  parameter int UPSAMPLING_FACTOR = 10,
  parameter int PRESCALER_FACTOR  = 1000,
  parameter int GAIN              = 4000
) (
  input  logic                    aclk,
  input  logic                    resetn,
  input  logic [1:0]              mode,
  input  logic [5:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int SCW = $clog2(UPSAMPLING_FACTOR) + 1;
  localparam int PCW = $clog2(PRESCALER_FACTOR) + 1;
  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(UPSAMPLING_FACTOR - 1);
  localparam logic [PCW-1:0] LAST_PRE    = PCW'(PRESCALER_FACTOR - 1);

  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [63:0] SAT_MAX = 64'(OUT_MAX);
  localparam logic signed [63:0] SAT_MIN = 64'(OUT_MIN);
  localparam logic signed [63:0] GAIN_S  = 64'(GAIN);

  typedef enum logic [1:0] {IDLE, EMIT, HOLD} state_t;

  // Symmetric clamp: the most negative code is never produced.
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [63:0] v);
    if (v > SAT_MAX)      sat = OUT_MAX;
    else if (v < SAT_MIN) sat = OUT_MIN;
    else                  sat = v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] map_axis(input logic [2:0] g,
                                                            input logic [1:0] k);
    logic [2:0]        n;
    logic signed [63:0] lvl;
    int                ni;
    int                nl;
    case (k)
      2'd1:    n = {2'b00, g[0]};
      2'd2:    n = {1'b0, g[1], g[1] ^ g[0]};
      default: n = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endcase
    ni  = int'(n);
    nl  = (1 << k) - 1;
    lvl = 64'(2 * ni - nl);
    lvl = lvl * GAIN_S;
    map_axis = sat(lvl);
  endfunction

  state_t                  state, state_n;
  logic [SCW-1:0]          scnt, scnt_n;
  logic [PCW-1:0]          pcnt, pcnt_n;
  logic                    tvalid_n, tready_n;
  logic [2*DATA_WIDTH-1:0] tdata_n, mapped_word, next_sample;
  logic [2:0]              re_g, im_g;
  logic [1:0]              k;
  logic                    in_fire;

  assign in_fire = (state == IDLE) && s_axis_tvalid && s_axis_tready;

  always_comb begin
    k    = 2'd1;
    re_g = {2'b00, s_axis_tdata[0]};
    im_g = {2'b00, s_axis_tdata[1]};
    case (mode)
      2'd1: begin
        k    = 2'd2;
        re_g = {1'b0, s_axis_tdata[1:0]};
        im_g = {1'b0, s_axis_tdata[3:2]};
      end
      2'd2: begin
        k    = 2'd3;
        re_g = s_axis_tdata[2:0];
        im_g = s_axis_tdata[5:3];
      end
      default: ;
    endcase
  end

  assign mapped_word = {map_axis(im_g, k), map_axis(re_g, k)};

`ifdef QAM_HOLD_MODE_EN
  logic [2*DATA_WIDTH-1:0] hold_word;

  always_ff @(posedge aclk) begin
    if (in_fire) hold_word <= mapped_word;
  end

  assign next_sample = hold_word;
`else
  assign next_sample = '0;
`endif

  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    pcnt_n   = pcnt;
    tvalid_n = m_axis_tvalid;
    tdata_n  = m_axis_tdata;
    case (state)
      IDLE: begin
        tvalid_n = 1'b0;
        if (in_fire) begin
          tdata_n  = mapped_word;
          tvalid_n = 1'b1;
          scnt_n   = '0;
          state_n  = EMIT;
        end
      end
      EMIT: begin
        if (m_axis_tready) begin
          scnt_n = scnt + 1'b1;
          if (scnt == LAST_SAMPLE) begin
            tvalid_n = 1'b0;
            tdata_n  = '0;
            state_n  = IDLE;
          end else if (PRESCALER_FACTOR > 0) begin
            tvalid_n = 1'b0;
            pcnt_n   = '0;
            state_n  = HOLD;
          end else begin
            tdata_n = next_sample;
          end
        end
      end
      HOLD: begin
        if (pcnt == LAST_PRE) begin
          tdata_n  = next_sample;
          tvalid_n = 1'b1;
          state_n  = EMIT;
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    tready_n = (state_n == IDLE);
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      scnt          <= '0;
      pcnt          <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      state         <= state_n;
      scnt          <= scnt_n;
      pcnt          <= pcnt_n;
      s_axis_tready <= tready_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tdata  <= tdata_n;
    end
  end

endmodule

// File: tb/tb_qam_mapper_upsampler.sv
// Bench for qam_mapper_upsampler: spec-level symbol model plus scoreboard, and directed literal checks.
module tb_qam_mapper_upsampler;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [5:0]  s_tdata = 6'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;

  logic [1:0]  mode2 = 2'd0;
  logic [5:0]  s_tdata2 = 6'd0;
  logic        s_tvalid2 = 1'b0;
  logic        s_tready2;
  logic [31:0] m_tdata2;
  logic        m_tvalid2;
  logic        m_tready2 = 1'b1;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          hs_q[$];

  qam_mapper_upsampler #(.DATA_WIDTH(16), .UPSAMPLING_FACTOR(10), .PRESCALER_FACTOR(2), .GAIN(4000)) dut (
    .aclk(aclk), .resetn(resetn), .mode(mode), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready));

  qam_mapper_upsampler #(.DATA_WIDTH(16), .UPSAMPLING_FACTOR(1), .PRESCALER_FACTOR(0), .GAIN(5000)) dut2 (
    .aclk(aclk), .resetn(resetn), .mode(mode2), .s_axis_tdata(s_tdata2), .s_axis_tvalid(s_tvalid2),
    .s_axis_tready(s_tready2), .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2));

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Level of one axis straight from the constellation definition.
  function automatic int model_level(input int k, input int g, input int gain);
    int n, b, v;
    n = 0;
    b = 0;
    for (int i = k - 1; i >= 0; i--) begin
      b = b ^ ((g >> i) & 1);
      n = n * 2 + b;
    end
    v = (2 * n - ((1 << k) - 1)) * gain;
    if (v > 32767) v = 32767;
    if (v < -32767) v = -32767;
    return v;
  endfunction

  function automatic logic [31:0] model_word(input int m, input int d, input int gain);
    int k, re, im;
    k  = (m == 1) ? 2 : (m == 2) ? 3 : 1;
    re = model_level(k, d & ((1 << k) - 1), gain);
    im = model_level(k, (d >> k) & ((1 << k) - 1), gain);
    return {im[15:0], re[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic        stall_prev;
    logic [31:0] prev_data;
    logic [31:0] e;
    stall_prev = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", {31'd0, m_tvalid}, 32'd1);
          check("stall_data", m_tdata, prev_data);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("extra_sample", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("sample", m_tdata, e);
          end
          hs_q.push_back(cyc);
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Offers one symbol, queues its expected samples, returns one cycle after the input handshake.
  task automatic send(input logic [1:0] m, input logic [5:0] d);
    int          t;
    logic [31:0] w;
    t = 0;
    while (!s_tready && t < 2000) begin
      step();
      t++;
    end
    check("send_ready_timeout", {31'd0, s_tready}, 32'd1);
    w = model_word(int'(m), int'(d), 4000);
    exp_q.push_back(w);
    for (int i = 1; i < 10; i++) begin
`ifdef QAM_HOLD_MODE_EN
      exp_q.push_back(w);
`else
      exp_q.push_back(32'd0);
`endif
    end
    mode     = m;
    s_tdata  = d;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    mode     = 2'd2;
    s_tdata  = 6'h3F;
  endtask

  task automatic first_sample(input string name, input logic [31:0] exp);
    check({name, "_valid"}, {31'd0, m_tvalid}, 32'd1);
    check(name, m_tdata, exp);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !s_tready) && t < 2000) begin
      step();
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, {31'd0, s_tready}, 32'd1);
  endtask

  task automatic send2(input string name, input logic [1:0] m, input logic [5:0] d,
                       input logic [31:0] exp);
    int t;
    t = 0;
    while (!s_tready2 && t < 100) begin
      step();
      t++;
    end
    mode2     = m;
    s_tdata2  = d;
    s_tvalid2 = 1'b1;
    step();
    s_tvalid2 = 1'b0;
    mode2     = 2'd0;
    check({name, "_valid"}, {31'd0, m_tvalid2}, 32'd1);
    check(name, m_tdata2, exp);
    step();
    check({name, "_drop"}, {31'd0, m_tvalid2}, 32'd0);
    check({name, "_ready"}, {31'd0, s_tready2}, 32'd1);
  endtask

  initial begin
    int t;
    fork
      monitor();
    join_none

    repeat (3) step();
    check("rst_s_ready", {31'd0, s_tready}, 32'd0);
    check("rst_m_valid", {31'd0, m_tvalid}, 32'd0);
    check("rst_m_data", m_tdata, 32'd0);
    resetn = 1'b1;
    check("rel_ready_low", {31'd0, s_tready}, 32'd0);
    step();
    check("rel_ready_high", {31'd0, s_tready}, 32'd1);

    // Model pinned against hand-derived constellation points.
    check("model_16q_0000", model_word(1, 6'b000000, 4000), 32'hD120D120);
    check("model_64q_sat", model_word(2, 6'b100100, 5000), 32'h7FFF7FFF);

    // Scenario 1: first symbol, zero-stuffed samples three cycles apart.
    hs_q.delete();
    send(2'd1, 6'b000000);
    first_sample("s1_first", 32'hD120D120);
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      check("s1_ready_low", {31'd0, s_tready}, 32'd0);
      step();
      t++;
    end
    wait_done("s1");
    check("s1_count", 32'(hs_q.size()), 32'd10);
    for (int i = 1; i < hs_q.size(); i++) check("s1_gap", 32'(hs_q[i] - hs_q[i-1]), 32'd3);

    // Scenario 2/3: mapping across modes.
    send(2'd1, 6'b001011); first_sample("s2_16q_1011", 32'h2EE00FA0); wait_done("s2a");
    send(2'd0, 6'b000010); first_sample("s2_qpsk_10", 32'h0FA0F060); wait_done("s2b");
    send(2'd3, 6'b000010); first_sample("s2_mode3", 32'h0FA0F060); wait_done("s2c");
    send(2'd0, 6'b111110); first_sample("s2_qpsk_upper", 32'h0FA0F060); wait_done("s2d");
    send(2'd2, 6'b100100); first_sample("s3_64q", 32'h6D606D60); wait_done("s3");

    // Scenario 4: backpressure on the first and second samples.
    hs_q.delete();
    send(2'd1, 6'b001011);
    first_sample("s4_first", 32'h2EE00FA0);
    m_tready = 1'b0;
    repeat (5) begin
      step();
      check("s4_hold_valid", {31'd0, m_tvalid}, 32'd1);
    end
    m_tready = 1'b1;
    step();
    t = 0;
    while (!m_tvalid && t < 50) begin
      step();
      t++;
    end
    m_tready = 1'b0;
    repeat (5) begin
      step();
      check("s4_hold2_valid", {31'd0, m_tvalid}, 32'd1);
    end
    m_tready = 1'b1;
    wait_done("s4");
    check("s4_count", 32'(hs_q.size()), 32'd10);

    // Scenario 5: reset during the fourth sample.
    hs_q.delete();
    send(2'd1, 6'b001011);
    t = 0;
    while (hs_q.size() < 3 && t < 100) begin
      step();
      t++;
    end
    resetn = 1'b0;
    #1;
    check("s5_rst_valid", {31'd0, m_tvalid}, 32'd0);
    check("s5_rst_data", m_tdata, 32'd0);
    check("s5_rst_ready", {31'd0, s_tready}, 32'd0);
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
    check("s5_rel_low", {31'd0, s_tready}, 32'd0);
    step();
    check("s5_rel_high", {31'd0, s_tready}, 32'd1);
    hs_q.delete();
    send(2'd2, 6'b100100);
    first_sample("s5_next", 32'h6D606D60);
    wait_done("s5");
    check("s5_count", 32'(hs_q.size()), 32'd10);

    // Saturation and single-sample symbols on the GAIN=5000 instance.
    send2("g5_64q_max", 2'd2, 6'b100100, 32'h7FFF7FFF);
    send2("g5_64q_min", 2'd2, 6'b000000, 32'h80018001);
    send2("g5_16q_1011", 2'd1, 6'b001011, 32'h3A981388);
    for (int d = 0; d < 64; d++) send2("g5_sweep", 2'd2, 6'(d), model_word(2, d, 5000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
